rv32_data_mem_bridge: RTL and testbench
=======================================

Name: rv32_data_mem_bridge

Overview:
- Sits directly downstream of the CPU core's data-memory port (enable, read, address, write-data, read-data).
- Converts that port into a valid/ready request bus plus a response channel toward data RAM or peripherals.
- Posts stores into a small write buffer so the core is not stalled on them.
- Stalls the core on loads until read data returns, with misalignment and timeout error handling.

Parameters:
WBUF_DEPTH, 4, posted-write FIFO entries; power of 2, minimum 2.
TIMEOUT, 255, maximum cycles spent in RD_WAIT before the read is aborted with an error; minimum 1.

Ports:
clk  in  1  single clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
core_en  in  1  core access request
core_rd  in  1  1 = load, 0 = store
core_addr  in  32  byte address; must be word aligned
core_wdata  in  32  store data
core_stall  out  1  core must hold its request and pipeline
core_rdata  out  32  load data, registered
core_rdata_valid  out  1  one-cycle pulse when core_rdata is updated
core_err  out  1  one-cycle pulse: misaligned access or read timeout
bus_req_valid  out  1  bus request valid
bus_req_ready  in  1  bus accepts request
bus_req_we  out  1  1 = write
bus_req_addr  out  32  word-aligned address
bus_req_wdata  out  32  write data
bus_rsp_valid  in  1  read response valid; write requests get no response
bus_rsp_rdata  in  32  read response data

Behaviour:
- Reset, sampled on a clk edge while rst_n = 0, clears all state:
  - FSM to IDLE, FIFO pointers and count to 0, timeout counter to 0.
  - core_rdata = 0; core_rdata_valid, core_err and bus_req_valid = 0.
  - Reset mid-operation abandons any outstanding read; a bus_rsp_valid arriving afterwards while in IDLE is ignored.
- Acceptance: a request is accepted when core_en = 1 and core_stall = 0. core_stall is combinational and is 1 when:
  - the state is not IDLE, or
  - core_en & !core_rd & FIFO full.
- Misaligned access (core_addr[1:0] != 0): consumed in the accept cycle.
  - core_err pulses next cycle; nothing is issued on the bus and the FIFO is unchanged.
  - A misaligned load also pulses core_rdata_valid with core_rdata = 0.
- Store: an accepted aligned store pushes {addr, wdata} into the FIFO. No stall unless the FIFO is full.
  - Push and pop in the same cycle are allowed.
  - Full blocks new stores even when a pop occurs in the same cycle.
- FIFO drain: when in IDLE or DRAIN and the FIFO is non-empty:
  - bus_req_valid = 1, we = 1, address and data from the FIFO head.
  - Pop on bus_req_valid & bus_req_ready.
  - Writes are posted and complete on the handshake.
- FSM states: IDLE, DRAIN, RD_REQ, RD_WAIT.
  - IDLE: accepted aligned load latches the address, then goes to DRAIN if the FIFO is non-empty, else RD_REQ. Loads never bypass older stores.
  - DRAIN: drains the FIFO; goes to RD_REQ in the cycle after the final pop.
  - RD_REQ: bus_req_valid = 1, we = 0; on ready goes to RD_WAIT and clears the timeout counter.
  - RD_WAIT: counter increments each cycle.
    - On bus_rsp_valid: core_rdata <= bus_rsp_rdata, core_rdata_valid pulses next cycle, go to IDLE.
    - If the counter reaches TIMEOUT without a response: core_rdata <= 0, core_rdata_valid and core_err pulse, go to IDLE.
    - A response and the timeout in the same cycle: the response wins.
- Latency:
  - Load with empty FIFO, ready = 1, response the cycle after the handshake: accept at N, request at N+1, response at N+2, core_rdata_valid at N+3, core_stall low from N+3.
  - Each buffered store adds at least 1 cycle.
- bus_req_* held stable while valid & !ready. The bridge never de-asserts valid before the handshake.
- Only one read is outstanding at a time. bus_rsp_valid outside RD_WAIT is ignored.

Decomposition:
- Shared package rv32_mem_pkg:
  - FSM state encoding constants: IDLE = 0, DRAIN = 1, RD_REQ = 2, RD_WAIT = 3.
  - 64-bit wbuf entry layout {addr[31:0], data[31:0]}.
  - Misalignment-check helper.
- One sub-module, rv32_wbuf_fifo: synchronous FIFO with parameterised depth.
  - push/pop, full/empty, head data.
  - Synchronous active-low reset.

Test Plan:
- Store to 0x100 with 0xCAFEF00D, ready = 1: no stall; bus write to 0x100 / 0xCAFEF00D one cycle later; no response expected.
- Five back-to-back stores with ready = 0, WBUF_DEPTH = 4:
  - stall asserts on the 5th store.
  - Raise ready: writes appear in order 0x0, 0x4, 0x8, 0xC, then the 5th store is accepted.
- Store to 0x20 then immediate load from 0x20:
  - bus shows the write before the read.
  - Response 0x12345678 gives core_rdata = 0x12345678 with one core_rdata_valid pulse.
- Load from 0x102: core_err and core_rdata_valid pulse, core_rdata = 0, no bus activity.
- Load with no response, TIMEOUT = 8: after 8 RD_WAIT cycles core_err pulses, core_rdata = 0, stall drops; a late bus_rsp_valid is ignored.
- Reset held low in RD_WAIT, then a bus response arrives after release: all outputs at 0, FSM in IDLE, the response is ignored and the next load works normally.

Source files
------------

// File: rtl/rv32_mem_pkg.sv
// Shared types for the RV32 data-memory bridge: FSM states, write-buffer entry
// layout and the alignment check used on every core access.
package rv32_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_RD_REQ  = 2'd2,
        ST_RD_WAIT = 2'd3
    } bridge_state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wbuf_entry_t;

    localparam int WBUF_ENTRY_W = $bits(wbuf_entry_t);

    function automatic logic is_misaligned(input logic [1:0] addr_lo);
        return addr_lo != 2'b00;
    endfunction

endpackage

// File: rtl/rv32_wbuf_fifo.sv
// Posted-store FIFO: synchronous, power-of-two depth, head entry always visible.
// A push into a full FIFO is dropped even if a pop happens in the same cycle.
module rv32_wbuf_fifo
    import rv32_mem_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  wbuf_entry_t push_entry,
    input  logic        pop,
    output wbuf_entry_t head_entry,
    output logic        full,
    output logic        empty,
    output logic        last_entry
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    wbuf_entry_t   mem_q [DEPTH];
    wbuf_entry_t   mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push;
    logic          do_pop;

    always_comb begin
        full       = (count_q == DEPTH_C);
        empty      = (count_q == '0);
        last_entry = (count_q == CW'(1));
        do_push    = push & ~full;
        do_pop     = pop & ~empty;
        head_entry = mem_q[rd_ptr_q];

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (do_push) begin
            mem_d[wr_ptr_q] = push_entry;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end

        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only read once the count covers them.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/rv32_data_mem_bridge.sv
// Bridges the core data port to a valid/ready bus: stores are posted through a
// write buffer, loads stall the core until data, misalignment or timeout.
module rv32_data_mem_bridge
    import rv32_mem_pkg::*;
#(
    parameter int WBUF_DEPTH = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        core_en,
    input  logic        core_rd,
    input  logic [31:0] core_addr,
    input  logic [31:0] core_wdata,
    output logic        core_stall,
    output logic [31:0] core_rdata,
    output logic        core_rdata_valid,
    output logic        core_err,
    output logic        bus_req_valid,
    input  logic        bus_req_ready,
    output logic        bus_req_we,
    output logic [31:0] bus_req_addr,
    output logic [31:0] bus_req_wdata,
    input  logic        bus_rsp_valid,
    input  logic [31:0] bus_rsp_rdata
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT - 1);

    bridge_state_e state_q, state_d;
    logic [31:0]   rd_addr_q, rd_addr_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          rdata_valid_q, rdata_valid_d;
    logic          err_q, err_d;

    logic          accept;
    logic          misaligned;
    logic          wbuf_push;
    logic          wbuf_pop;
    logic          drain_active;
    wbuf_entry_t   wbuf_in;
    wbuf_entry_t   wbuf_head;
    logic          wbuf_full;
    logic          wbuf_empty;
    logic          wbuf_last;

    rv32_wbuf_fifo #(
        .DEPTH (WBUF_DEPTH)
    ) u_wbuf (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (wbuf_push),
        .push_entry (wbuf_in),
        .pop        (wbuf_pop),
        .head_entry (wbuf_head),
        .full       (wbuf_full),
        .empty      (wbuf_empty),
        .last_entry (wbuf_last)
    );

    // The buffer drains whenever no read owns the bus, so stores never wait on loads.
    always_comb begin
        core_stall   = (state_q != ST_IDLE) | (core_en & ~core_rd & wbuf_full);
        accept       = core_en & ~core_stall;
        misaligned   = is_misaligned(core_addr[1:0]);
        wbuf_push    = accept & ~core_rd & ~misaligned;
        wbuf_in.addr = core_addr;
        wbuf_in.data = core_wdata;

        drain_active  = ((state_q == ST_IDLE) | (state_q == ST_DRAIN)) & ~wbuf_empty;
        wbuf_pop      = drain_active & bus_req_ready;
        bus_req_valid = drain_active | (state_q == ST_RD_REQ);
        bus_req_we    = drain_active;
        bus_req_addr  = drain_active ? wbuf_head.addr : rd_addr_q;
        bus_req_wdata = drain_active ? wbuf_head.data : '0;
    end

    always_comb begin
        state_d       = state_q;
        rd_addr_d     = rd_addr_q;
        timer_d       = timer_q;
        rdata_d       = rdata_q;
        rdata_valid_d = 1'b0;
        err_d         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept && misaligned) begin
                    err_d = 1'b1;
                    if (core_rd) begin
                        rdata_d       = '0;
                        rdata_valid_d = 1'b1;
                    end
                end else if (accept && core_rd) begin
                    rd_addr_d = core_addr;
                    state_d   = wbuf_empty ? ST_RD_REQ : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (wbuf_empty || (wbuf_pop && wbuf_last)) begin
                    state_d = ST_RD_REQ;
                end
            end
            ST_RD_REQ: begin
                if (bus_req_ready) begin
                    state_d = ST_RD_WAIT;
                    timer_d = '0;
                end
            end
            ST_RD_WAIT: begin
                timer_d = timer_q + TW'(1);
                // A response arriving on the final timeout cycle still counts.
                if (bus_rsp_valid) begin
                    rdata_d       = bus_rsp_rdata;
                    rdata_valid_d = 1'b1;
                    state_d       = ST_IDLE;
                end else if (timer_q == TIMEOUT_LAST) begin
                    rdata_d       = '0;
                    rdata_valid_d = 1'b1;
                    err_d         = 1'b1;
                    state_d       = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            rd_addr_q     <= '0;
            timer_q       <= '0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            rd_addr_q     <= rd_addr_d;
            timer_q       <= timer_d;
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
            err_q         <= err_d;
        end
    end

    assign core_rdata       = rdata_q;
    assign core_rdata_valid = rdata_valid_q;
    assign core_err         = err_q;

endmodule

// File: tb/tb_rv32_data_mem_bridge.sv
// Directed bench for rv32_data_mem_bridge: a program-order model predicts bus
// traffic and core responses, a bus-slave process answers reads from its own RAM.
module tb_rv32_data_mem_bridge;

    logic        clk;
    logic        rst_n;
    logic        core_en;
    logic        core_rd;
    logic [31:0] core_addr;
    logic [31:0] core_wdata;
    logic        core_stall;
    logic [31:0] core_rdata;
    logic        core_rdata_valid;
    logic        core_err;
    logic        bus_req_valid;
    logic        bus_req_ready;
    logic        bus_req_we;
    logic [31:0] bus_req_addr;
    logic [31:0] bus_req_wdata;
    logic        bus_rsp_valid;
    logic [31:0] bus_rsp_rdata;

    rv32_data_mem_bridge #(
        .WBUF_DEPTH (4),
        .TIMEOUT    (8)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .core_en          (core_en),
        .core_rd          (core_rd),
        .core_addr        (core_addr),
        .core_wdata       (core_wdata),
        .core_stall       (core_stall),
        .core_rdata       (core_rdata),
        .core_rdata_valid (core_rdata_valid),
        .core_err         (core_err),
        .bus_req_valid    (bus_req_valid),
        .bus_req_ready    (bus_req_ready),
        .bus_req_we       (bus_req_we),
        .bus_req_addr     (bus_req_addr),
        .bus_req_wdata    (bus_req_wdata),
        .bus_rsp_valid    (bus_rsp_valid),
        .bus_rsp_rdata    (bus_rsp_rdata)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } bus_txn_t;

    typedef struct {
        logic        err;
        logic        valid;
        logic [31:0] rdata;
    } core_rsp_t;

    bus_txn_t    bus_q[$];
    core_rsp_t   rsp_q[$];
    logic [31:0] model_mem [logic [31:0]];
    logic [31:0] slave_mem [logic [31:0]];

    int   assert_count;
    int   fail_count;
    int   cycle;
    logic rsp_enable;
    logic inject_rsp;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    function automatic logic [31:0] default_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assert_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Drive one core access until accepted, then record what the bus and core must see.
    task automatic applyStimulus(input logic rd, input logic [31:0] addr, input logic [31:0] wdata,
                                 output int start_cycle, output int acc_cycle, output logic first_stall);
        bus_txn_t  t;
        core_rsp_t r;
        logic      accepted;
        core_en    = 1'b1;
        core_rd    = rd;
        core_addr  = addr;
        core_wdata = wdata;
        accepted   = 1'b0;
        start_cycle = 0;
        acc_cycle   = 0;
        first_stall = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (n == 0) begin
                start_cycle = cycle;
                first_stall = core_stall;
            end
            if (!core_stall) begin
                accepted  = 1'b1;
                acc_cycle = cycle;
                break;
            end
        end
        checkOutput("accept", {31'd0, accepted}, 32'd1);
        if (accepted) begin
            if (addr[1:0] != 2'b00) begin
                r.err = 1'b1; r.valid = rd; r.rdata = 32'd0;
                rsp_q.push_back(r);
            end else if (!rd) begin
                t.we = 1'b1; t.addr = addr; t.wdata = wdata;
                bus_q.push_back(t);
                model_mem[addr] = wdata;
            end else begin
                t.we = 1'b0; t.addr = addr; t.wdata = 32'd0;
                bus_q.push_back(t);
                r.err   = !rsp_enable;
                r.valid = 1'b1;
                if (!rsp_enable) r.rdata = 32'd0;
                else r.rdata = model_mem.exists(addr) ? model_mem[addr] : default_word(addr);
                rsp_q.push_back(r);
            end
        end
        @(posedge clk);
        #1;
        core_en = 1'b0;
    endtask

    task automatic waitDrain();
        logic done;
        done = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (bus_q.size() == 0 && rsp_q.size() == 0 && !core_stall) begin
                done = 1'b1;
                break;
            end
        end
        checkOutput("drain_done", {31'd0, done}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    // Bus slave: captures handshakes at negedge, answers reads one cycle later.
    initial begin
        logic        rd_hs;
        logic [31:0] rd_a;
        bus_rsp_valid = 1'b0;
        bus_rsp_rdata = 32'd0;
        forever begin
            @(negedge clk);
            rd_hs = 1'b0;
            rd_a  = bus_req_addr;
            if (rst_n && bus_req_valid && bus_req_ready) begin
                if (bus_req_we) slave_mem[bus_req_addr] = bus_req_wdata;
                else rd_hs = 1'b1;
            end
            @(posedge clk);
            #1;
            bus_rsp_valid = (rd_hs && rsp_enable) || inject_rsp;
            if (inject_rsp) bus_rsp_rdata = 32'hDEAD_BEEF;
            else if (rd_hs) bus_rsp_rdata = slave_mem.exists(rd_a) ? slave_mem[rd_a] : default_word(rd_a);
            else bus_rsp_rdata = 32'd0;
        end
    end

    // Every-cycle comparison of bus handshakes and core responses against the model.
    initial begin
        logic      hold_pend;
        bus_txn_t  held;
        bus_txn_t  e;
        core_rsp_t r;
        hold_pend = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hold_pend = 1'b0;
                continue;
            end
            if (hold_pend) begin
                checkOutput("hold_valid", {31'd0, bus_req_valid}, 32'd1);
                checkOutput("hold_we", {31'd0, bus_req_we}, {31'd0, held.we});
                checkOutput("hold_addr", bus_req_addr, held.addr);
                checkOutput("hold_wdata", bus_req_wdata, held.wdata);
            end
            if (bus_req_valid && bus_req_ready) begin
                checkOutput("bus_txn_expected", {31'd0, bus_q.size() != 0}, 32'd1);
                if (bus_q.size() != 0) begin
                    e = bus_q.pop_front();
                    checkOutput("bus_we", {31'd0, bus_req_we}, {31'd0, e.we});
                    checkOutput("bus_addr", bus_req_addr, e.addr);
                    if (e.we) checkOutput("bus_wdata", bus_req_wdata, e.wdata);
                end
            end
            hold_pend  = bus_req_valid && !bus_req_ready;
            held.we    = bus_req_we;
            held.addr  = bus_req_addr;
            held.wdata = bus_req_wdata;
            if (core_rdata_valid || core_err) begin
                checkOutput("rsp_expected", {31'd0, rsp_q.size() != 0}, 32'd1);
                if (rsp_q.size() != 0) begin
                    r = rsp_q.pop_front();
                    checkOutput("rsp_err", {31'd0, core_err}, {31'd0, r.err});
                    checkOutput("rsp_valid", {31'd0, core_rdata_valid}, {31'd0, r.valid});
                    if (r.valid) checkOutput("rsp_rdata", core_rdata, r.rdata);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int   st, acc, delta;
        logic fs;
        logic found;
        rst_n = 1'b0; core_en = 1'b0; core_rd = 1'b0; core_addr = 32'd0; core_wdata = 32'd0;
        bus_req_ready = 1'b0; rsp_enable = 1'b1; inject_rsp = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_stall", {31'd0, core_stall}, 32'd0);
        checkOutput("reset_rdata", core_rdata, 32'd0);
        checkOutput("reset_rvalid", {31'd0, core_rdata_valid}, 32'd0);
        checkOutput("reset_err", {31'd0, core_err}, 32'd0);
        checkOutput("reset_bus_valid", {31'd0, bus_req_valid}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus_req_ready = 1'b1;

        $display("[TB] posted store");
        applyStimulus(1'b0, 32'h100, 32'hCAFE_F00D, st, acc, fs);
        checkOutput("store_no_stall", {31'd0, fs}, 32'd0);
        @(negedge clk);
        checkOutput("store_bus_valid", {31'd0, bus_req_valid}, 32'd1);
        checkOutput("store_bus_we", {31'd0, bus_req_we}, 32'd1);
        checkOutput("store_bus_addr", bus_req_addr, 32'h100);
        checkOutput("store_bus_wdata", bus_req_wdata, 32'hCAFE_F00D);
        waitDrain();

        $display("[TB] write buffer full");
        bus_req_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 32'(i * 4), 32'h1000 + 32'(i), st, acc, fs);
            checkOutput("fill_no_stall", {31'd0, fs}, 32'd0);
        end
        fork
            applyStimulus(1'b0, 32'h10, 32'h1004, st, acc, fs);
            begin
                repeat (3) @(posedge clk);
                #1;
                bus_req_ready = 1'b1;
            end
        join
        checkOutput("full_stall", {31'd0, fs}, 32'd1);
        checkOutput("full_wait_cycles", 32'(acc - st), 32'd4);
        waitDrain();

        $display("[TB] store then load same address");
        applyStimulus(1'b0, 32'h20, 32'h1234_5678, st, acc, fs);
        applyStimulus(1'b1, 32'h20, 32'd0, st, acc, fs);
        waitDrain();
        checkOutput("raw_rdata", core_rdata, 32'h1234_5678);

        $display("[TB] misaligned accesses");
        applyStimulus(1'b1, 32'h102, 32'd0, st, acc, fs);
        @(negedge clk);
        checkOutput("mis_ld_err", {31'd0, core_err}, 32'd1);
        checkOutput("mis_ld_valid", {31'd0, core_rdata_valid}, 32'd1);
        checkOutput("mis_ld_rdata", core_rdata, 32'd0);
        checkOutput("mis_ld_bus", {31'd0, bus_req_valid}, 32'd0);
        @(posedge clk); #1;
        applyStimulus(1'b0, 32'h105, 32'h5555_AAAA, st, acc, fs);
        @(negedge clk);
        checkOutput("mis_st_err", {31'd0, core_err}, 32'd1);
        checkOutput("mis_st_valid", {31'd0, core_rdata_valid}, 32'd0);
        checkOutput("mis_st_bus", {31'd0, bus_req_valid}, 32'd0);
        waitDrain();

        $display("[TB] load latency");
        applyStimulus(1'b1, 32'h200, 32'd0, st, acc, fs);
        found = 1'b0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (core_rdata_valid) begin found = 1'b1; break; end
        end
        checkOutput("lat_found", {31'd0, found}, 32'd1);
        checkOutput("lat_cycles", 32'(cycle - acc), 32'd3);
        checkOutput("lat_rdata", core_rdata, 32'h5A5A_0200);
        checkOutput("lat_stall", {31'd0, core_stall}, 32'd0);
        waitDrain();

        $display("[TB] read timeout");
        rsp_enable = 1'b0;
        applyStimulus(1'b1, 32'h40, 32'd0, st, acc, fs);
        found = 1'b0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (core_err) begin found = 1'b1; break; end
        end
        checkOutput("to_found", {31'd0, found}, 32'd1);
        delta = cycle - acc;
        checkOutput("to_cycles", 32'(delta), 32'd10);
        checkOutput("to_rdata", core_rdata, 32'd0);
        checkOutput("to_stall", {31'd0, core_stall}, 32'd0);
        @(negedge clk); inject_rsp = 1'b1;
        @(negedge clk); inject_rsp = 1'b0;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            checkOutput("late_rsp_valid", {31'd0, core_rdata_valid}, 32'd0);
            checkOutput("late_rsp_rdata", core_rdata, 32'd0);
        end
        rsp_enable = 1'b1;
        waitDrain();

        $display("[TB] reset during read wait");
        rsp_enable = 1'b0;
        applyStimulus(1'b1, 32'h80, 32'd0, st, acc, fs);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        rsp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_stall", {31'd0, core_stall}, 32'd0);
        checkOutput("rst_rdata", core_rdata, 32'd0);
        checkOutput("rst_rvalid", {31'd0, core_rdata_valid}, 32'd0);
        checkOutput("rst_err", {31'd0, core_err}, 32'd0);
        checkOutput("rst_bus_valid", {31'd0, bus_req_valid}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk); inject_rsp = 1'b1;
        @(negedge clk); inject_rsp = 1'b0;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            checkOutput("post_rst_valid", {31'd0, core_rdata_valid}, 32'd0);
            checkOutput("post_rst_rdata", core_rdata, 32'd0);
            checkOutput("post_rst_stall", {31'd0, core_stall}, 32'd0);
        end
        rsp_enable = 1'b1;
        @(posedge clk); #1;
        applyStimulus(1'b1, 32'h20, 32'd0, st, acc, fs);
        waitDrain();
        checkOutput("post_rst_load", core_rdata, 32'h1234_5678);

        checkOutput("bus_q_empty", 32'(bus_q.size()), 32'd0);
        checkOutput("rsp_q_empty", 32'(rsp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
